// File: rtl/list_lookup_decoder_if.sv
// Handshake and configuration bundle for list_lookup_decoder.
// master drives instructions/config and consumes results; slave is the decoder.
interface list_lookup_decoder_if #(
    parameter int XLEN     = 32,
    parameter int NENTRIES = 8,
    parameter int SIGW     = 3
);
    localparam int IDXW = $clog2(NENTRIES);

    logic            cfg_we;
    logic [IDXW-1:0] cfg_idx;
    logic            cfg_en;
    logic [XLEN-1:0] cfg_mask;
    logic [XLEN-1:0] cfg_match;
    logic [SIGW-1:0] cfg_sigs;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_inst;

    logic            out_valid;
    logic            out_ready;
    logic [SIGW-1:0] out_sigs;
    logic            out_hit;
    logic [IDXW-1:0] out_idx;
    logic            out_illegal;

    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_mask, cfg_match, cfg_sigs,
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_sigs, out_hit, out_idx, out_illegal
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_mask, cfg_match, cfg_sigs,
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_sigs, out_hit, out_idx, out_illegal
    );
endinterface

// File: rtl/list_lookup_decoder.sv
// Table-driven instruction decoder: lowest enabled matching entry wins, one-deep registered output.
// Define LIST_LOOKUP_DECODER_STATS_EN to add accept/illegal counters with stat_clr.
module list_lookup_decoder #(
    parameter int             XLEN         = 32,
    parameter int             NENTRIES     = 8,
    parameter int             SIGW         = 3,
    parameter logic [SIGW-1:0] DEFAULT_SIGS = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    list_lookup_decoder_if.slave bus
`ifdef LIST_LOOKUP_DECODER_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_decoded,
    output logic [31:0]          stat_illegal
`endif
);
    localparam int IDXW = $clog2(NENTRIES);
    localparam logic [IDXW:0] NENT_W = (IDXW+1)'(NENTRIES);

    logic [NENTRIES-1:0] r_en;
    logic [XLEN-1:0]     r_mask  [NENTRIES];
    logic [XLEN-1:0]     r_match [NENTRIES];
    logic [SIGW-1:0]     r_sigs  [NENTRIES];

    logic                r_out_valid;
    logic [SIGW-1:0]     r_out_sigs;
    logic                r_out_hit;
    logic [IDXW-1:0]     r_out_idx;

    logic                w_cfg_ok;
    logic                w_accept;
    logic                w_hit;
    logic [IDXW-1:0]     w_idx;
    logic [SIGW-1:0]     w_sigs;

    assign w_cfg_ok     = bus.cfg_we && ({1'b0, bus.cfg_idx} < NENT_W);
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Decode reads the table as it stands before any write on this edge.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_sigs = DEFAULT_SIGS;
        for (int unsigned i = 0; i < NENTRIES; i++) begin
            if (!w_hit && r_en[i] &&
                ((bus.in_inst & r_mask[i]) == (r_match[i] & r_mask[i]))) begin
                w_hit  = 1'b1;
                w_idx  = IDXW'(i);
                w_sigs = r_sigs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en    <= '0;
            r_mask  <= '{default: '0};
            r_match <= '{default: '0};
            r_sigs  <= '{default: '0};
        end else if (w_cfg_ok) begin
            r_en[bus.cfg_idx]    <= bus.cfg_en;
            r_mask[bus.cfg_idx]  <= bus.cfg_mask;
            r_match[bus.cfg_idx] <= bus.cfg_match;
            r_sigs[bus.cfg_idx]  <= bus.cfg_sigs;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_sigs  <= DEFAULT_SIGS;
            r_out_hit   <= 1'b0;
            r_out_idx   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sigs  <= w_sigs;
            r_out_hit   <= w_hit;
            r_out_idx   <= w_idx;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_sigs    = r_out_sigs;
    assign bus.out_hit     = r_out_hit;
    assign bus.out_idx     = r_out_idx;
    assign bus.out_illegal = !r_out_hit;

`ifdef LIST_LOOKUP_DECODER_STATS_EN
    logic [31:0] r_stat_decoded;
    logic [31:0] r_stat_illegal;

    always_ff @(posedge clk) begin
        if (!reset || stat_clr) begin
            r_stat_decoded <= '0;
            r_stat_illegal <= '0;
        end else if (w_accept) begin
            r_stat_decoded <= r_stat_decoded + 32'd1;
            if (!w_hit) begin
                r_stat_illegal <= r_stat_illegal + 32'd1;
            end
        end
    end

    assign stat_decoded = r_stat_decoded;
    assign stat_illegal = r_stat_illegal;
`endif
endmodule

// File: tb/tb_list_lookup_decoder.sv
// Scoreboard bench for list_lookup_decoder: reference model queues expected results, monitor compares.
module tb_list_lookup_decoder;
    localparam int NENT = 6;
    localparam int IW   = 3;
    localparam logic [2:0] DEF = 3'd5;

    typedef struct packed {
        logic [2:0]    sigs;
        logic          hit;
        logic [IW-1:0] idx;
    } exp_t;

    logic clk;
    logic reset;
    logic stat_clr;

    list_lookup_decoder_if #(.XLEN(32), .NENTRIES(NENT), .SIGW(3)) bus ();

`ifdef LIST_LOOKUP_DECODER_STATS_EN
    logic [31:0] stat_decoded;
    logic [31:0] stat_illegal;
`endif

    list_lookup_decoder #(
        .XLEN(32), .NENTRIES(NENT), .SIGW(3), .DEFAULT_SIGS(DEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef LIST_LOOKUP_DECODER_STATS_EN
        ,
        .stat_clr(stat_clr),
        .stat_decoded(stat_decoded),
        .stat_illegal(stat_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference table and state
    logic        m_en    [NENT];
    logic [31:0] m_mask  [NENT];
    logic [31:0] m_match [NENT];
    logic [2:0]  m_sigs  [NENT];
    logic        m_valid;
    exp_t        m_hold;
    exp_t        q[$];
    logic [31:0] m_dec, m_ill;

    int n_checks = 0;
    int n_err    = 0;

    function automatic exp_t ref_decode(logic [31:0] inst);
        exp_t e;
        e.sigs = DEF;
        e.hit  = 1'b0;
        e.idx  = '0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (m_en[i] && (((inst ^ m_match[i]) & m_mask[i]) == 32'd0)) begin
                e.sigs = m_sigs[i];
                e.hit  = 1'b1;
                e.idx  = IW'(i);
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: samples inputs at the active edge
    initial begin
        m_valid = 1'b0;
        m_dec   = '0;
        m_ill   = '0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int i = 0; i < NENT; i++) begin
                    m_en[i] = 1'b0; m_mask[i] = '0; m_match[i] = '0; m_sigs[i] = '0;
                end
                m_valid = 1'b0;
                m_hold  = '{sigs: DEF, hit: 1'b0, idx: '0};
                q.delete();
                m_dec = '0;
                m_ill = '0;
            end else begin
                logic acc;
                exp_t e;
                acc = bus.in_valid && (!m_valid || bus.out_ready);
                e   = ref_decode(bus.in_inst);
                if (acc) begin
                    q.push_back(e);
                    m_hold  = e;
                    m_valid = 1'b1;
                end else if (m_valid && bus.out_ready) begin
                    m_valid = 1'b0;
                end
                if (stat_clr) begin
                    m_dec = '0;
                    m_ill = '0;
                end else if (acc) begin
                    m_dec = m_dec + 1;
                    if (!e.hit) m_ill = m_ill + 1;
                end
                if (bus.cfg_we && int'(bus.cfg_idx) < NENT) begin
                    m_en[bus.cfg_idx]    = bus.cfg_en;
                    m_mask[bus.cfg_idx]  = bus.cfg_mask;
                    m_match[bus.cfg_idx] = bus.cfg_match;
                    m_sigs[bus.cfg_idx]  = bus.cfg_sigs;
                end
            end
        end
    end

    // monitor: compares on the falling edge
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
            e = m_hold;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL scoreboard: got out_valid=1 expected no pending result at %0t", $time);
                end else begin
                    e = q[0];
                end
            end
            chk("out_sigs", 32'(bus.out_sigs), 32'(e.sigs));
            chk("out_hit", 32'(bus.out_hit), 32'(e.hit));
            chk("out_idx", 32'(bus.out_idx), 32'(e.idx));
            chk("out_illegal", 32'(bus.out_illegal), 32'(!e.hit));
`ifdef LIST_LOOKUP_DECODER_STATS_EN
            chk("stat_decoded", stat_decoded, m_dec);
            chk("stat_illegal", stat_illegal, m_ill);
`endif
            if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg(input int idx, input logic en, input logic [31:0] mask,
                       input logic [31:0] match, input logic [2:0] sigs);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = IW'(idx);
        bus.cfg_en    = en;
        bus.cfg_mask  = mask;
        bus.cfg_match = match;
        bus.cfg_sigs  = sigs;
        tick();
    endtask

    task automatic issue(input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        tick();
    endtask

    initial begin
        logic [31:0] masks [5];
        masks[0] = 32'hFFFF_FFFF; masks[1] = 32'hFFFF_0000; masks[2] = 32'h0000_FFFF;
        masks[3] = 32'h0000_007F; masks[4] = 32'h0000_0000;

        reset = 1'b0; stat_clr = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
        bus.cfg_mask = '0; bus.cfg_match = '0; bus.cfg_sigs = '0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.out_ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();

        // basic table and back-to-back decode
        cfg(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_277B, 3'd4);
        cfg(1, 1'b1, 32'hFFFF_FFFF, 32'h0000_257B, 3'd1);
        issue(32'h0000_277B);
        issue(32'h0000_257B);
        issue(32'h0000_1234);
        bus.in_valid = 1'b0; tick();

        // wildcard entry below higher-priority exact entries
        cfg(2, 1'b1, 32'h0, 32'h0, 3'd2);
        issue(32'h0000_257B);
        issue(32'hDEAD_BEEF);
        bus.in_valid = 1'b0; tick();

        // stall: second instruction waits for out_ready
        issue(32'h0000_277B);
        bus.out_ready = 1'b0;
        issue(32'h0000_257B); tick(); tick();
        bus.out_ready = 1'b1; tick();
        bus.in_valid = 1'b0; tick(); tick();

        // config write coincident with accept, then out-of-range writes
        bus.in_valid = 1'b1; bus.in_inst = 32'h0000_257B;
        cfg(1, 1'b1, 32'hFFFF_FFFF, 32'h0000_257B, 3'd3);
        issue(32'h0000_257B);
        bus.in_valid = 1'b0;
        cfg(NENT, 1'b1, 32'h0, 32'h0, 3'd7);
        cfg(NENT + 1, 1'b1, 32'h0, 32'h0, 3'd6);
        cfg(2, 1'b0, 32'h0, 32'h0, 3'd2);
        issue(32'h0000_1234);
        issue(32'h0000_257B);
        bus.in_valid = 1'b0; tick();

        // reset while stalled
        issue(32'h0000_277B);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; tick(); tick();
        reset = 1'b0; tick();
        reset = 1'b1; bus.out_ready = 1'b1;
        issue(32'h0000_277B);
        bus.in_valid = 1'b0; tick();

        // five accepts with two misses, then clear coincident with an accept
        cfg(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_277B, 3'd4);
        issue(32'h0000_277B); issue(32'h0000_0001); issue(32'h0000_277B);
        issue(32'h0000_0002); issue(32'h0000_277B);
        bus.in_valid = 1'b0; tick();
        stat_clr = 1'b1; issue(32'h0000_0003);
        stat_clr = 1'b0; bus.in_valid = 1'b0; tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            int j;
            if ($urandom_range(0, 3) == 0) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_idx   = IW'($urandom_range(0, 7));
                bus.cfg_en    = ($urandom_range(0, 3) != 0);
                bus.cfg_mask  = masks[$urandom_range(0, 4)];
                bus.cfg_match = $urandom;
                bus.cfg_sigs  = 3'($urandom);
            end
            j = $urandom_range(0, NENT - 1);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_inst   = ($urandom_range(0, 1) == 0) ?
                            ((m_match[j] & m_mask[j]) | ($urandom & ~m_mask[j])) : $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            stat_clr      = ($urandom_range(0, 40) == 0);
            reset         = ($urandom_range(0, 120) != 0);
            tick();
        end
        reset = 1'b1; stat_clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/list_lookup_decoder.md
Name: list_lookup_decoder

Overview:
- Parametrised, pipelined successor to the single-output list-lookup instruction decoder.
- Holds a runtime-programmable table of NENTRIES (mask, match, signal-vector) entries and decodes one instruction per cycle; the lowest matching index wins.
- Output is registered behind a valid/ready handshake, plus hit index and illegal-instruction flag.
- Sits between instruction fetch and the control path.

Parameters:
- XLEN, 32, instruction width
- NENTRIES, 8, table depth (2..64)
- SIGW, 3, control-signal vector width
- DEFAULT_SIGS, 0, signal vector driven when no entry hits
- IDXW, clog2(NENTRIES), index width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- cfg_we  in  1  table write strobe
- cfg_idx  in  IDXW  entry written
- cfg_en  in  1  entry-enable bit written
- cfg_mask  in  XLEN  care bits
- cfg_match  in  XLEN  compare value
- cfg_sigs  in  SIGW  signal vector for entry
- in_valid  in  1  instruction valid
- in_ready  out  1  decoder can accept
- in_inst  in  XLEN  instruction
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts
- out_sigs  out  SIGW  decoded control signals
- out_hit  out  1  some enabled entry matched
- out_idx  out  IDXW  winning entry (0 when no hit)
- out_illegal  out  1  equals !out_hit

Behaviour:
- Reset (reset==0 at a clk edge): all entry-enable bits=0, mask/match/sigs=0; out_valid=0, out_sigs=DEFAULT_SIGS, out_hit=0, out_idx=0, out_illegal=1.
- Entry i hits when en[i] && ((in_inst & mask[i]) == (match[i] & mask[i])). mask=0 with en=1 is a wildcard.
- Priority: the lowest hitting index supplies sigs and idx. No hit gives DEFAULT_SIGS, hit=0, idx=0, illegal=1.
- in_ready = !out_valid || out_ready (combinational, one-entry pipeline).
- Accept (in_valid && in_ready): the decode is registered; out_* update on the next edge, out_valid=1. Latency is exactly 1 cycle.
- out_valid && out_ready && no accept: out_valid goes to 0; the other out_* fields hold their last values.
- Stall (out_valid && !out_ready): all out_* hold stable; in_ready=0.
- Back-to-back: with out_ready held 1, one result per cycle, no bubbles.
- Config write: takes effect at the edge.
  - A decode accepted in the same cycle uses the pre-write table.
  - An output already registered is never recomputed by a later write.
  - cfg_idx >= NENTRIES: write ignored.
- Config writes are accepted regardless of handshake state.
- Reset mid-operation: pending output is dropped (out_valid=0); table is cleared.
- in_valid while !in_ready: no state change; the source must hold in_inst.

Optional Feature:
- Macro: LIST_LOOKUP_DECODER_STATS_EN.
- Defined: adds output ports stat_decoded[31:0] and stat_illegal[31:0], both reset to 0.
  - stat_decoded increments on every accept.
  - stat_illegal increments on every accept with no hit.
  - Both wrap from 0xFFFFFFFF to 0.
  - Input stat_clr (1) zeroes both at the edge, with priority over increments.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Defaults, after reset: entry0 en=1 mask=FFFFFFFF match=0000277B sigs=4; entry1 en=1 mask=FFFFFFFF match=0000257B sigs=1; out_ready=1. Drive 277B, 257B, 1234 on consecutive cycles -> next three cycles give out_sigs 4/1/0, out_idx 0/1/0, out_illegal 0/0/1, out_valid continuously 1.
- Priority: entry2 mask=0 sigs=2 en=1; drive 0000257B -> sigs=1 idx=1. Drive DEADBEEF -> sigs=2 idx=2 hit=1.
- Stall: out_ready=0 for 3 cycles after an accept of 277B -> out_valid=1, out_sigs=4 held, in_ready=0. New in_inst=257B is not accepted until out_ready=1, and then appears one cycle later.
- Config race: same cycle accept 257B and write entry1 sigs=3 -> result sigs=1. Next decode of 257B -> sigs=3. Write with cfg_idx=NENTRIES (when NENTRIES is not a power of two) -> table unchanged.
- Reset mid-stream: reset=0 for one edge while out_valid=1 and stalled -> out_valid=0, out_illegal=1; decode of 277B afterwards -> illegal=1, sigs=DEFAULT_SIGS.
- With LIST_LOOKUP_DECODER_STATS_EN defined: 5 accepts, 2 of them illegal -> stat_decoded=5, stat_illegal=2. Pulse stat_clr coincident with an accept -> both read 0 next cycle.
